// File: rtl/mcp9808_target.sv
// I2C target emulating an MCP9808 temperature sensor (address {4'b0011, addr_pins}).
// Define MCP9808_TGT_ALERT_EN to enable the T_A limit flags and the alert output.
`timescale 1ns/1ps
module mcp9808_target #(
  parameter logic [15:0] ID_MANUF  = 16'h0054,
  parameter logic [15:0] ID_DEVICE = 16'h0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  addr_pins,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [12:0] temp_in,
  output logic        shdn,
  output logic        alert,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  state_t      state, state_n;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_q, sda_q;
  logic        scl_rise, scl_fall, start_c, stop_c;

  logic [3:0]  cnt, cnt_n;
  logic [7:0]  sh, sh_n;
  logic        rw, rw_n;
  logic [3:0]  ptr, ptr_n;
  logic        wlo, wlo_n;
  logic [4:0]  wmsb, wmsb_n;
  logic [15:0] rd_word, rd_word_n;
  logic        rlo, rlo_n;
  logic        mack, mack_n;
  logic        oe_n;
  logic        wr_en;

  logic [10:0] cfg;
  logic [10:0] t_upper, t_lower, t_crit;
  logic [1:0]  res;
  logic [12:0] ta;
  logic [2:0]  flags;
  logic [15:0] rd_val;
  logic [7:0]  cur_byte;
  logic [2:0]  bit_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl_rise = scl_sync[1] & ~scl_q;
  assign scl_fall = ~scl_sync[1] & scl_q;
  assign start_c  = scl_sync[1] & scl_q & sda_q & ~sda_sync[1];
  assign stop_c   = scl_sync[1] & scl_q & ~sda_q & sda_sync[1];

  always_comb begin
    rd_val = '0;
    case (ptr)
      4'h1:    rd_val = {5'b0, cfg};
      4'h2:    rd_val = {3'b0, t_upper, 2'b0};
      4'h3:    rd_val = {3'b0, t_lower, 2'b0};
      4'h4:    rd_val = {3'b0, t_crit, 2'b0};
      4'h5:    rd_val = {flags, ta};
      4'h6:    rd_val = ID_MANUF;
      4'h7:    rd_val = ID_DEVICE;
      // RES is a single byte; duplicating it makes the MSB/LSB read cycle repeat it
      4'h8:    rd_val = {6'b0, res, 6'b0, res};
      default: rd_val = '0;
    endcase
  end

  assign cur_byte = rlo ? rd_word[7:0] : rd_word[15:8];
  assign bit_idx  = 3'd7 - cnt[2:0];

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sh_n      = sh;
    rw_n      = rw;
    ptr_n     = ptr;
    wlo_n     = wlo;
    wmsb_n    = wmsb;
    rd_word_n = rd_word;
    rlo_n     = rlo;
    mack_n    = mack;
    oe_n      = sda_oe;
    wr_en     = 1'b0;
    if (stop_c) begin
      state_n = IDLE;
      oe_n    = 1'b0;
    end else if (start_c) begin
      state_n = ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise && cnt != 4'd8) begin
            sh_n  = {sh[6:0], sda_sync[1]};
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_n = '0;
            oe_n  = 1'b1;
            if (state == ADDR) begin
              if (sh[7:1] == {4'b0011, addr_pins}) begin
                rw_n    = sh[0];
                state_n = ADDR_ACK;
              end else begin
                oe_n    = 1'b0;
                state_n = WAIT_STOP;
              end
            end else if (state == PTR) begin
              ptr_n   = sh[3:0];
              wlo_n   = 1'b0;
              state_n = PTR_ACK;
            end else begin
              state_n = WDATA_ACK;
              if (ptr == 4'h8 || wlo) begin
                wr_en = 1'b1;
                wlo_n = 1'b0;
              end else begin
                wmsb_n = sh[4:0];
                wlo_n  = 1'b1;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_n = '0;
            if (rw) begin
              rd_word_n = rd_val;
              rlo_n     = 1'b0;
              oe_n      = ~rd_val[15];
              state_n   = RDATA;
            end else begin
              oe_n    = 1'b0;
              state_n = PTR;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            oe_n    = 1'b0;
            state_n = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise && cnt != 4'd8) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              oe_n    = 1'b0;
              state_n = RACK;
            end else begin
              oe_n = ~cur_byte[bit_idx];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            mack_n = ~sda_sync[1];
          end else if (scl_fall) begin
            if (!mack) begin
              state_n = WAIT_STOP;
            end else begin
              cnt_n   = '0;
              state_n = RDATA;
              // a fresh snapshot is taken only ahead of each MSB byte
              if (rlo) begin
                rd_word_n = rd_val;
                rlo_n     = 1'b0;
                oe_n      = ~rd_val[15];
              end else begin
                rlo_n = 1'b1;
                oe_n  = ~rd_word[7];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      rw      <= 1'b0;
      ptr     <= '0;
      wlo     <= 1'b0;
      wmsb    <= '0;
      rd_word <= '0;
      rlo     <= 1'b0;
      mack    <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      rw      <= rw_n;
      ptr     <= ptr_n;
      wlo     <= wlo_n;
      wmsb    <= wmsb_n;
      rd_word <= rd_word_n;
      rlo     <= rlo_n;
      mack    <= mack_n;
      sda_oe  <= oe_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg     <= '0;
      t_upper <= '0;
      t_lower <= '0;
      t_crit  <= '0;
      res     <= 2'b11;
      ta      <= '0;
    end else begin
      if (!cfg[8]) ta <= temp_in;
      if (wr_en) begin
        case (ptr)
          4'h1:    cfg     <= {wmsb[2:0], sh};
          4'h2:    t_upper <= {wmsb, sh[7:2]};
          4'h3:    t_lower <= {wmsb, sh[7:2]};
          4'h4:    t_crit  <= {wmsb, sh[7:2]};
          4'h8:    res     <= sh[1:0];
          default: ;
        endcase
      end
    end
  end

`ifdef MCP9808_TGT_ALERT_EN
  always_comb begin
    flags[2] = $signed(ta) >= $signed({t_crit, 2'b00});
    flags[1] = $signed(ta) >  $signed({t_upper, 2'b00});
    flags[0] = $signed(ta) <  $signed({t_lower, 2'b00});
  end

  always_ff @(posedge clk) begin
    if (rst) alert <= 1'b0;
    else     alert <= cfg[3] & (|flags);
  end
`else
  assign flags = '0;
  assign alert = 1'b0;
`endif

  assign shdn = cfg[8];
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mcp9808_target.sv
// Directed bench for mcp9808_target: bit-banged I2C initiator with hand-computed expectations.
`timescale 1ns/1ps
module tb_mcp9808_target;
  localparam int TH = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  addr_pins = 3'b000;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic [12:0] temp_in = 13'h0194;
  logic        sda_oe, shdn, alert, busy, sda_line;
  int unsigned passed = 0, total = 0;

`ifdef MCP9808_TGT_ALERT_EN
  localparam logic [15:0] TA_194 = 16'hC194;
  localparam logic [15:0] TA_1A0 = 16'h41A0;
  localparam logic        ALERT_EXP = 1'b1;
`else
  localparam logic [15:0] TA_194 = 16'h0194;
  localparam logic [15:0] TA_1A0 = 16'h01A0;
  localparam logic        ALERT_EXP = 1'b0;
`endif

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  mcp9808_target #(.ID_MANUF(16'h0054), .ID_DEVICE(16'h0400)) dut (
    .clk(clk), .rst(rst), .addr_pins(addr_pins), .scl_i(scl), .sda_i(sda_line),
    .sda_oe(sda_oe), .temp_in(temp_in), .shdn(shdn), .alert(alert), .busy(busy)
  );

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;
    #(TH/2) scl = 1'b1;
    #(TH/2) s = sda_line;
    #(TH/2) scl = 1'b0;
    #(TH/2);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    #(TH/2) scl = 1'b1;
    #(TH/2) sda_m = 1'b0;
    #(TH/2) scl = 1'b0;
    #(TH/2);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    #(TH/2) scl = 1'b1;
    #(TH/2) sda_m = 1'b1;
    #(TH);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack_m, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(~ack_m, s);
  endtask

  task automatic wr_reg(input logic [3:0] p, input logic [15:0] v, input logic two, output logic ok);
    logic a0, a1, a2, a3;
    bus_start();
    write_byte(8'h30, a0);
    write_byte({4'h0, p}, a1);
    a2 = 1'b1;
    if (two) write_byte(v[15:8], a2);
    write_byte(v[7:0], a3);
    bus_stop();
    ok = a0 & a1 & a2 & a3;
  endtask

  task automatic rd_reg(input logic [3:0] p, output logic [15:0] v, output logic ok);
    logic a0, a1, a2;
    bus_start();
    write_byte(8'h30, a0);
    write_byte({4'h0, p}, a1);
    bus_start();
    write_byte(8'h31, a2);
    read_byte(1'b1, v[15:8]);
    read_byte(1'b0, v[7:0]);
    bus_stop();
    ok = a0 & a1 & a2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (shdn !== 1'b0) $display("FAIL reset_shdn: got %b expected 0", shdn); else passed++;
    total++; if (alert !== 1'b0) $display("FAIL reset_alert: got %b expected 0", alert); else passed++;
    rst = 1'b0;
    #(TH);
  endtask

  task automatic test_read_ta();
    logic a0, a1, a2;
    logic [7:0] m, l;
    bus_start();
    write_byte(8'h30, a0);
    write_byte(8'h05, a1);
    bus_start();
    write_byte(8'h31, a2);
    read_byte(1'b1, m);
    read_byte(1'b0, l);
    total++; if ({a0, a1, a2} !== 3'b111) $display("FAIL ta_acks: got %b expected 111", {a0, a1, a2}); else passed++;
    total++; if (m !== TA_194[15:8]) $display("FAIL ta_msb: got %h expected %h", m, TA_194[15:8]); else passed++;
    total++; if (l !== 8'h94) $display("FAIL ta_lsb: got %h expected 94", l); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL busy_before_stop: got %b expected 1", busy); else passed++;
    bus_stop();
    total++; if (busy !== 1'b0) $display("FAIL busy_after_stop: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_addr_mismatch();
    logic a;
    logic ok;
    logic [15:0] v;
    bus_start();
    write_byte(8'h34, a);
    total++; if (a !== 1'b0) $display("FAIL mismatch_nack: got ack=%b expected 0", a); else passed++;
    total++; if (sda_oe !== 1'b0) $display("FAIL mismatch_sda_oe: got %b expected 0", sda_oe); else passed++;
    bus_stop();
    rd_reg(4'h6, v, ok);
    total++; if (ok !== 1'b1) $display("FAIL manuf_acks: got %b expected 1", ok); else passed++;
    total++; if (v !== 16'h0054) $display("FAIL manuf_id: got %h expected 0054", v); else passed++;
    rd_reg(4'h7, v, ok);
    total++; if (v !== 16'h0400) $display("FAIL device_id: got %h expected 0400", v); else passed++;
  endtask

  task automatic test_shutdown();
    logic ok;
    logic [15:0] v;
    wr_reg(4'h1, 16'h0100, 1'b1, ok);
    total++; if (ok !== 1'b1) $display("FAIL cfg_write_acks: got %b expected 1", ok); else passed++;
    total++; if (shdn !== 1'b1) $display("FAIL shdn_set: got %b expected 1", shdn); else passed++;
    temp_in = 13'h0200;
    repeat (20) @(posedge clk);
    rd_reg(4'h5, v, ok);
    total++; if (v !== TA_194) $display("FAIL ta_frozen: got %h expected %h", v, TA_194); else passed++;
    rd_reg(4'h1, v, ok);
    total++; if (v !== 16'h0100) $display("FAIL cfg_readback: got %h expected 0100", v); else passed++;
    wr_reg(4'h3, 16'hFFFF, 1'b1, ok);
    rd_reg(4'h3, v, ok);
    total++; if (v !== 16'h1FFC) $display("FAIL tlower_mask: got %h expected 1ffc", v); else passed++;
    wr_reg(4'h1, 16'hFFFF, 1'b1, ok);
    rd_reg(4'h1, v, ok);
    total++; if (v !== 16'h07FF) $display("FAIL cfg_mask: got %h expected 07ff", v); else passed++;
    wr_reg(4'h1, 16'h0000, 1'b1, ok);
    total++; if (shdn !== 1'b0) $display("FAIL shdn_clear: got %b expected 0", shdn); else passed++;
  endtask

  task automatic test_res();
    logic ok, a0, a1, a2;
    logic [15:0] v;
    logic [7:0] b0, b1, b2;
    rd_reg(4'h8, v, ok);
    total++; if (v !== 16'h0303) $display("FAIL res_default: got %h expected 0303", v); else passed++;
    wr_reg(4'h8, 16'h0000, 1'b0, ok);
    total++; if (ok !== 1'b1) $display("FAIL res_write_acks: got %b expected 1", ok); else passed++;
    bus_start();
    write_byte(8'h30, a0);
    write_byte(8'h08, a1);
    bus_start();
    write_byte(8'h31, a2);
    read_byte(1'b1, b0);
    read_byte(1'b1, b1);
    read_byte(1'b0, b2);
    bus_stop();
    total++; if ({b0, b1, b2} !== 24'h000000) $display("FAIL res_repeat: got %h expected 000000", {b0, b1, b2}); else passed++;
    wr_reg(4'h6, 16'h1234, 1'b1, ok);
    total++; if (ok !== 1'b1) $display("FAIL ro_write_acks: got %b expected 1", ok); else passed++;
    rd_reg(4'h6, v, ok);
    total++; if (v !== 16'h0054) $display("FAIL ro_unchanged: got %h expected 0054", v); else passed++;
    rd_reg(4'hC, v, ok);
    total++; if (ok !== 1'b1 || v !== 16'h0000) $display("FAIL ptr_above_8: got ok=%b %h expected ok=1 0000", ok, v); else passed++;
  endtask

  task automatic test_alert();
    logic ok;
    logic [15:0] v;
    wr_reg(4'h2, 16'h0190, 1'b1, ok);
    wr_reg(4'h4, 16'h0500, 1'b1, ok);
    wr_reg(4'h1, 16'h0008, 1'b1, ok);
    temp_in = 13'h01A0;
    repeat (10) @(posedge clk);
    rd_reg(4'h5, v, ok);
    total++; if (v !== TA_1A0) $display("FAIL ta_flags: got %h expected %h", v, TA_1A0); else passed++;
    total++; if (alert !== ALERT_EXP) $display("FAIL alert: got %b expected %b", alert, ALERT_EXP); else passed++;
    rd_reg(4'h2, v, ok);
    total++; if (v !== 16'h0190) $display("FAIL tupper_readback: got %h expected 0190", v); else passed++;
  endtask

  task automatic test_reset_mid();
    logic ok, a0, a1, a2, s;
    logic [7:0] m;
    logic [15:0] v;
    wr_reg(4'h1, 16'h0108, 1'b1, ok);
    bus_start();
    write_byte(8'h30, a0);
    write_byte(8'h05, a1);
    bus_start();
    write_byte(8'h31, a2);
    read_byte(1'b1, m);
    clk_bit(1'b1, s);
    clk_bit(1'b1, s);
    clk_bit(1'b1, s);
    sda_m = 1'b1;
    #(TH/2) scl = 1'b1;
    #(TH/4);
    total++; if (sda_oe !== 1'b1) $display("FAIL lsb_bit4_driven: got %b expected 1", sda_oe); else passed++;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    total++; if (sda_oe !== 1'b0) $display("FAIL rst_mid_sda_oe: got %b expected 0", sda_oe); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else passed++;
    total++; if (shdn !== 1'b0) $display("FAIL rst_mid_shdn: got %b expected 0", shdn); else passed++;
    @(negedge clk) rst = 1'b0;
    #(TH);
    rd_reg(4'h1, v, ok);
    total++; if (v !== 16'h0000) $display("FAIL rst_mid_cfg: got %h expected 0000", v); else passed++;
    rd_reg(4'h8, v, ok);
    total++; if (v !== 16'h0303) $display("FAIL rst_mid_res: got %h expected 0303", v); else passed++;
  endtask

  initial begin
    test_reset();
    test_read_ta();
    test_addr_mismatch();
    test_shutdown();
    test_res();
    test_alert();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mcp9808_target.md
# mcp9808_target

I2C target (slave) that emulates an MCP9808 temperature sensor on the board's SCL/SDA pins. It is the bench counterpart of our `mcp9808` initiator. It lets the initiator be exercised in simulation and on hardware without a physical sensor. Ambient temperature is supplied in parallel from the board; limits, configuration and resolution are held in internal registers that the initiator can write.

## Interface
- `ID_MANUF`, default 16'h0054: value returned from register 0x06.
- `ID_DEVICE`, default 16'h0400: value returned from register 0x07.
- `clk`  in  1: system clock; must run at least 16× SCL.
- `rst`  in  1: reset, synchronous, active-high; clock clk.
- `addr_pins`  in  3: A2..A0; target address = {4'b0011, addr_pins}.
- `scl_i`  in  1: SCL pin level (asynchronous).
- `sda_i`  in  1: SDA pin level (asynchronous).
- `sda_oe`  out  1: 1 = pull SDA low; 0 = release (open drain).
- `temp_in`  in  13: ambient temperature, two's complement, LSB = 1/16 °C.
- `shdn`  out  1: configuration bit 8 (shutdown).
- `alert`  out  1: alert output (see Configuration).
- `busy`  out  1: high from START until STOP.

## Operation
- Input path: scl_i/sda_i go through 2-flop synchronizers. Edges are detected on the synchronized copies.
- Bus conditions:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Repeated START from any state goes to ADDR. STOP from any state goes to IDLE and releases SDA.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
- ADDR: shift 8 bits MSB first.
  - Address mismatch: go to WAIT_STOP, SDA stays released (NACK).
  - Match with R/W=0: ACK, then PTR.
  - Match with R/W=1: ACK, then RDATA.
- PTR: ACK the pointer byte and store ptr[3:0]. Pointer values above 0x08 are ACKed and read as 0x0000.
- WDATA: the write register is selected by ptr.
  - 16-bit registers: MSB byte then LSB byte. Commit happens on the LSB byte's ACK.
  - Resolution register (0x08): one byte, committed on its ACK.
  - Further bytes are ACKed and the sequence repeats.
  - Writes to read-only registers are ACKed and discarded.
- Register map and write masks:
  - 0x01 CONFIG: bits [10:0] writable, rest read 0.
  - 0x02 T_UPPER, 0x03 T_LOWER, 0x04 T_CRIT: bits [12:2] writable, rest read 0.
  - 0x05 T_A: {flags[2:0], ta[12:0]}, read-only.
  - 0x06 and 0x07: parameters, read-only.
  - 0x08 RES: bits [1:0] writable.
- ta register tracks temp_in every clk while CONFIG[8]=0. While CONFIG[8]=1 (shutdown) it freezes.
- Read snapshot: the 16-bit read value is captured into the shift register at the ACK that precedes the MSB byte, so MSB and LSB are coherent.
  - Reads continue MSB, LSB, MSB... while the initiator ACKs; 8-bit RES repeats its single byte.
  - Initiator NACK in RACK: go to WAIT_STOP.
- Reset values: all outputs 0; CONFIG=0, limits=0, RES=2'b11, ptr=0, state IDLE.

## Timing
- Sample SDA on the synchronized SCL rising edge.
- Change sda_oe on the clk after the synchronized SCL falling edge, so SDA is stable throughout SCL high.
- ACK: assert sda_oe=1 from the falling edge after bit 8 until the next falling edge.
- Read data: sda_oe = ~bit. Release after the 8th bit's low phase so the initiator can drive ACK/NACK.
- Pin to internal detection latency: 2 clk (synchronizer) plus 1 clk (edge detect).
- START/STOP take priority over a data bit in the same cycle.
- A register commit and a `temp_in` change in the same cycle are both applied. Flags use the pre-commit limit values for that cycle.
- `rst` asserted mid-transfer: SDA released on the next clk edge, all registers return to reset values.

## Configuration
- `MCP9808_TGT_ALERT_EN` defined:
  - Flags are computed every clk as signed 13-bit compares: [15] crit = ta ≥ T_CRIT, [14] upper = ta > T_UPPER, [13] lower = ta < T_LOWER.
  - alert = CONFIG[3] & (crit | upper | lower), registered, 1 clk latency.
- Not defined: flags read as 0 and alert is tied 0.

## Test plan
- addr_pins=000, temp_in=13'h0194; write 0x30, ptr 0x05, repeated START, read 0x31 with two bytes → bytes 0x01 and 0x94, second byte NACKed, then STOP → busy=0.
- Address 0x1A with addr_pins=000 → SDA released at the ACK slot; a following access to 0x18 works normally.
- Write CONFIG 0x0100, then change temp_in to 13'h0200, then read T_A → 0x0194 (frozen) and shdn=1.
- Write RES 0x00, read RES three bytes → 0x00 repeated; write 0x06 then read → 0x0054.
- With MCP9808_TGT_ALERT_EN: T_UPPER=0x0190, CONFIG=0x0008, temp_in=0x01A0 → read T_A=0x41A0 and alert=1. Without the macro: read T_A=0x01A0 and alert=0.
- Assert rst during the LSB read bit 4 → sda_oe=0 next clk, CONFIG=0, state IDLE.
